// File: rtl/pc_unit_gen2_if.sv
//------------------------------------------------------------------------------
// pc_unit_gen2_if : request/response bundle between the front end and the PC.
// Optional return-address-stack signals are present when PC_RAS_EN is defined.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

interface pc_unit_gen2_if #(
  parameter int XLEN = 32
);
  logic            stall;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            trap_valid;
  logic            trap_ret;
  logic            halt_req;
  logic            resume;
  logic [XLEN-1:0] pc_out;
  logic [XLEN-1:0] pc_plus_step;
  logic [XLEN-1:0] epc_out;
  logic            misaligned;
  logic            halted;
`ifdef PC_RAS_EN
  logic            ras_push;
  logic            ras_pop;
  logic [XLEN-1:0] ras_top;
`endif

  modport master (
    output stall, redirect_valid, redirect_target, trap_valid, trap_ret,
           halt_req, resume,
`ifdef PC_RAS_EN
    output ras_push, ras_pop,
    input  ras_top,
`endif
    input  pc_out, pc_plus_step, epc_out, misaligned, halted
  );

  modport slave (
    input  stall, redirect_valid, redirect_target, trap_valid, trap_ret,
           halt_req, resume,
`ifdef PC_RAS_EN
    input  ras_push, ras_pop,
    output ras_top,
`endif
    output pc_out, pc_plus_step, epc_out, misaligned, halted
  );
endinterface

`default_nettype wire

// File: rtl/pc_unit_gen2.sv
//------------------------------------------------------------------------------
// pc_unit_gen2 : program counter with stall, redirect, trap/EPC and halt FSM.
// Define PC_RAS_EN to add a 4-entry circular return-address stack.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module pc_unit_gen2 #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(32'h0000_0000),
  parameter logic [XLEN-1:0] TRAP_VECTOR  = XLEN'(32'h0000_0100),
  parameter int              STEP         = 4
) (
  input wire logic      clk,
  input wire logic      rst,
  pc_unit_gen2_if.slave bus
);

  localparam logic [XLEN-1:0] c_STEP       = XLEN'(STEP);
  localparam logic [XLEN-1:0] c_ALIGN_MASK = XLEN'(STEP - 1);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_epc;
  logic            r_mis;
  logic [XLEN-1:0] w_pc_nxt;
  logic [XLEN-1:0] w_epc_nxt;
  logic            w_mis_nxt;
  logic [XLEN-1:0] w_pc_plus;
  logic [XLEN-1:0] w_target;
  logic            w_target_mis;
  logic            w_run;

  assign w_run        = (r_state == ST_RUN);
  assign w_pc_plus    = r_pc + c_STEP;
  assign w_target_mis = |(w_target & c_ALIGN_MASK);

`ifdef PC_RAS_EN
  logic [XLEN-1:0] r_ras_mem [4];
  logic [1:0]      r_ras_ptr;
  logic [2:0]      r_ras_cnt;
  logic [1:0]      w_ras_ptr_inc;
  logic [XLEN-1:0] w_ras_top;
  logic            w_ras_push;
  logic            w_ras_pop;

  assign w_ras_ptr_inc = r_ras_ptr + 2'd1;
  assign w_ras_top     = (r_ras_cnt == 3'd0) ? '0 : r_ras_mem[r_ras_ptr];
  assign w_ras_push    = w_run && bus.ras_push;
  assign w_ras_pop     = w_run && bus.ras_pop;
  assign bus.ras_top   = w_ras_top;

  // Push+pop on a non-empty stack rewrites the top; otherwise a push wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ras_ptr <= 2'd0;
      r_ras_cnt <= 3'd0;
    end else if (w_ras_push && w_ras_pop && (r_ras_cnt != 3'd0)) begin
      r_ras_mem[r_ras_ptr] <= w_pc_plus;
    end else if (w_ras_push) begin
      r_ras_mem[w_ras_ptr_inc] <= w_pc_plus;
      r_ras_ptr                <= w_ras_ptr_inc;
      if (r_ras_cnt != 3'd4) r_ras_cnt <= r_ras_cnt + 3'd1;
    end else if (w_ras_pop && (r_ras_cnt != 3'd0)) begin
      r_ras_ptr <= r_ras_ptr - 2'd1;
      r_ras_cnt <= r_ras_cnt - 3'd1;
    end
  end

  always_comb begin
    w_target = bus.redirect_target;
    if (bus.ras_pop) w_target = w_ras_top;
  end
`else
  always_comb begin
    w_target = bus.redirect_target;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_RUN;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_epc_nxt   = r_epc;
    w_mis_nxt   = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (bus.trap_valid) begin
          w_epc_nxt = r_pc;
          w_pc_nxt  = TRAP_VECTOR;
        end else if (bus.trap_ret) begin
          w_pc_nxt = r_epc;
        end else if (bus.redirect_valid) begin
          if (w_target_mis) w_mis_nxt = 1'b1;
          else              w_pc_nxt  = w_target;
        end else if (!bus.stall) begin
          w_pc_nxt = w_pc_plus;
        end
        // The PC update above still lands on the halting edge.
        if (bus.halt_req && !bus.trap_valid) w_state_nxt = ST_HALT;
      end
      ST_HALT: begin
        if (bus.resume) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc  <= RESET_VECTOR;
      r_epc <= '0;
      r_mis <= 1'b0;
    end else begin
      r_pc  <= w_pc_nxt;
      r_epc <= w_epc_nxt;
      r_mis <= w_mis_nxt;
    end
  end

  assign bus.pc_out       = r_pc;
  assign bus.pc_plus_step = w_pc_plus;
  assign bus.epc_out      = r_epc;
  assign bus.misaligned   = r_mis;
  assign bus.halted       = (r_state == ST_HALT);

endmodule

`default_nettype wire

// File: doc/pc_unit_gen2.md
Name: pc_unit_gen2

Overview:
Parametrised second-generation program counter for the single-cycle/pipelined core front end; replaces the plain registered PC.
- Adds configurable width, reset vector, trap vector and instruction step.
- Adds stall, branch/jump redirect, trap entry/return with an EPC register, and a halt/resume state machine.
- Output feeds IMEM address directly; registered, zero-latency to IMEM read.

Parameters:
XLEN, 32, PC and target width in bits.
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
TRAP_VECTOR, 32'h0000_0100, PC value loaded on trap entry.
STEP, 4, sequential increment in bytes (power of two, >=2).

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
stall  input  1  hold PC this cycle
redirect_valid  input  1  branch/jump taken
redirect_target  input  XLEN  branch/jump destination
trap_valid  input  1  exception/interrupt request
trap_ret  input  1  return from trap (load EPC)
halt_req  input  1  enter HALT state
resume  input  1  leave HALT state
pc_out  output  XLEN  current PC
pc_plus_step  output  XLEN  pc_out + STEP (combinational)
epc_out  output  XLEN  saved exception PC
misaligned  output  1  one-cycle pulse: rejected misaligned redirect
halted  output  1  high while in HALT

Behaviour:
- Reset is synchronous, active-high, on one clock; rst has top priority. On rst: pc_out=RESET_VECTOR, epc_out=0, misaligned=0, halted=0, state=RUN.
- State machine:
  - RUN: PC updates every cycle according to the priority list below.
  - HALT: pc_out frozen, halted=1, all requests except rst and resume ignored.
  - RUN->HALT when halt_req=1 and no trap_valid; the PC update of that cycle still applies.
  - HALT->RUN on resume=1; PC resumes incrementing the following cycle.
- Priority in RUN (highest first):
  1. trap_valid: epc<=pc_out, pc<=TRAP_VECTOR.
  2. trap_ret: pc<=epc.
  3. redirect_valid: pc<=redirect_target. If target[log2(STEP)-1:0]!=0, pc holds, misaligned pulses 1 for one cycle, and the redirect is dropped.
  4. stall: pc holds.
  5. Otherwise: pc<=pc+STEP.
- trap_valid overrides stall. A trap in the same cycle as a redirect saves the current pc_out, not the target.
- Arithmetic is modulo 2^XLEN. pc=2^XLEN-STEP increments to 0 with no flag.
- trap_ret with epc never written returns to 0.
- misaligned is registered: high in the cycle after the offending request, otherwise 0.

Optional Feature:
PC_RAS_EN
- Defined: adds a return-address stack, depth 4, with ports ras_push (in, 1), ras_pop (in, 1) and ras_top (out, XLEN).
  - A push stores pc_plus_step when the current instruction is a call.
  - A pop in the same cycle as redirect_valid makes the redirect use ras_top instead of redirect_target.
  - Push when full overwrites the oldest entry (circular).
  - Pop when empty returns 0 and the pointer stays.
  - Simultaneous push+pop replaces the top entry.
  - rst clears the pointer and count.
- Undefined: no RAS ports or logic; redirect always uses redirect_target.

Test Plan:
- rst=1 for 2 cycles, then release with no inputs -> pc_out 0x0, 0x4, 0x8, 0xC on consecutive cycles.
- At pc=0x8, stall=1 for 3 cycles -> pc_out stays 0x8 for those 3 cycles, then 0xC.
- At pc=0x10, redirect_valid=1 with target 0x40 -> next pc 0x40. Target 0x42 -> pc holds 0x10 then 0x14, misaligned=1 for exactly one cycle.
- At pc=0x20, trap_valid=1 together with redirect_valid=1 (target 0x80) -> pc=0x100, epc_out=0x20. Later trap_ret=1 -> pc=0x20.
- halt_req at pc=0x30 -> pc 0x34 then frozen, halted=1. Redirect during HALT ignored. resume -> next pc 0x38. rst asserted mid-HALT -> pc=0x0, halted=0.
- XLEN=8, STEP=4, pc=0xFC -> next pc 0x00. With PC_RAS_EN: push at 0x10 and 0x20, then two pop+redirects -> pc=0x24, then 0x14.
